// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Architectural register file of the single-cycle datapath. It provides two
//   combinational read ports that feed ALU operands A and B, and one
//   synchronous write port that takes the write-back value (ALU result or
//   load data). Register 0 always reads as zero. An optional write-through
//   bypass forwards WD to a read port in the same cycle. A registered
//   write-back echo reports each committed write to the debug/trace path.
//
// Parameters
//   DATA_W  register width; matches the ALU operand width
//   ADDR_W  register address width; there are 2**ADDR_W registers
//   BYPASS  1: a read of the address being committed this cycle returns WD
//           0: a read always returns the stored value
//
// Ports
//   CLK       in   rising-edge clock
//   RESET     in   asynchronous active-high reset; clears every register and the echo
//   RA1, RA2  in   read addresses (rs, rt)
//   RD1, RD2  out  combinational read data (ALU A, ALU B)
//   WE        in   write enable
//   WA        in   write address
//   WD        in   write data
//   STALL     in   blocks the write (and therefore the bypass) at this edge
//   WB_VALID  out  a write committed at the last rising edge
//   WB_ADDR   out  address of the last committed write (held otherwise)
//   WB_DATA   out  data of the last committed write (held otherwise)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic              STALL,
    output logic              WB_VALID,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic [DATA_W-1:0] WB_DATA
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;

    logic              commit;
    logic [DATA_W-1:0] rd1_d, rd2_d;

    // A write commits only when enabled, not stalled and not aimed at
    // register 0. It is also masked while RESET is high, so a write that
    // collides with reset is lost and cannot leak through the bypass.
    assign commit = WE & ~STALL & (WA != '0) & ~RESET;

    // Register 0 is never written (commit excludes WA==0) and is cleared by
    // reset, so its storage always holds zero; the read path still forces
    // zero explicitly so the bypass can never forward onto it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[WA] <= WD;
        end
    end

    always_comb begin
        wb_valid_d = commit;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (commit) begin
            wb_addr_d = WA;
            wb_data_d = WD;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Both ports follow the same rule, so RA1==RA2 always yields identical data.
    always_comb begin
        rd1_d = '0;
        if (RA1 != '0) begin
            if ((BYPASS != 0) && commit && (WA == RA1)) begin
                rd1_d = WD;
            end else begin
                rd1_d = regs_q[RA1];
            end
        end
    end

    always_comb begin
        rd2_d = '0;
        if (RA2 != '0) begin
            if ((BYPASS != 0) && commit && (WA == RA2)) begin
                rd2_d = WD;
            end else begin
                rd2_d = regs_q[RA2];
            end
        end
    end

    assign RD1      = rd1_d;
    assign RD2      = rd2_d;
    assign WB_VALID = wb_valid_q;
    assign WB_ADDR  = wb_addr_q;
    assign WB_DATA  = wb_data_q;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        CLK;
    logic        RESET;
    logic [4:0]  RA1, RA2, WA;
    logic [31:0] WD;
    logic        WE, STALL;

    logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        wb_valid, wb_valid_nb;
    logic [4:0]  wb_addr, wb_addr_nb;
    logic [31:0] wb_data, wb_data_nb;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic [31:0] alu_result;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .CLK(CLK), .RESET(RESET), .RA1(RA1), .RA2(RA2), .RD1(rd1), .RD2(rd2),
        .WE(WE), .WA(WA), .WD(WD), .STALL(STALL),
        .WB_VALID(wb_valid), .WB_ADDR(wb_addr), .WB_DATA(wb_data)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .CLK(CLK), .RESET(RESET), .RA1(RA1), .RA2(RA2), .RD1(rd1_nb), .RD2(rd2_nb),
        .WE(WE), .WA(WA), .WD(WD), .STALL(STALL),
        .WB_VALID(wb_valid_nb), .WB_ADDR(wb_addr_nb), .WB_DATA(wb_data_nb)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then step away from it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; WA = a; WD = d;
        tick();
        WE = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    initial begin
        RESET = 1'b1; WE = 1'b0; STALL = 1'b0;
        RA1 = 5'd0; RA2 = 5'd0; WA = 5'd0; WD = 32'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // reset state
        #1;
        RA1 = 5'd4; RA2 = 5'd17;
        #1;
        check("rst_rd1", rd1, 32'd0);
        check("rst_rd2", rd2, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        tick();
        RESET = 1'b0;
        tick();

        // basic write / read with echo
        write_reg(5'd5, 32'h1234_5678);
        RA1 = 5'd5; RA2 = 5'd5;
        #1;
        check("wr_rd1", rd1, 32'h1234_5678);
        check("wr_rd2", rd2, 32'h1234_5678);
        check("wr_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("wr_wb_addr", {27'd0, wb_addr}, 32'd5);
        check("wr_wb_data", wb_data, 32'h1234_5678);
        tick();
        check("wr_wb_valid_drop", {31'd0, wb_valid}, 32'd0);
        check("wr_wb_data_hold", wb_data, 32'h1234_5678);

        // register 0 discards writes
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; RA1 = 5'd0;
        #1;
        check("r0_rd1_pre", rd1, 32'd0);
        tick();
        WE = 1'b0;
        #1;
        check("r0_rd1_post", rd1, 32'd0);
        check("r0_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("r0_wb_addr_hold", {27'd0, wb_addr}, 32'd5);

        // bypass versus non-bypass build
        write_reg(5'd7, 32'h11);
        WE = 1'b1; WA = 5'd7; WD = 32'h22; RA1 = 5'd7; RA2 = 5'd7;
        #1;
        check("byp_rd1", rd1, 32'h22);
        check("byp_rd2", rd2, 32'h22);
        check("nobyp_rd1_pre", rd1_nb, 32'h11);
        check("nobyp_rd2_pre", rd2_nb, 32'h11);
        tick();
        WE = 1'b0;
        model[7] = 32'h22;
        #1;
        check("byp_rd1_post", rd1, 32'h22);
        check("nobyp_rd1_post", rd1_nb, 32'h22);

        // stall blocks the write and the bypass
        write_reg(5'd3, 32'h10);
        STALL = 1'b1; WE = 1'b1; WA = 5'd3; WD = 32'h99; RA1 = 5'd3; RA2 = 5'd3;
        #1;
        check("stall_rd1_pre", rd1, 32'h10);
        tick();
        check("stall_rd1_post", rd1, 32'h10);
        check("stall_rd2_post", rd2, 32'h10);
        check("stall_wb_valid", {31'd0, wb_valid}, 32'd0);
        STALL = 1'b0; WE = 1'b0;

        // mid-cycle reset after filling every register
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A5_0000 + 32'(i));
        RA1 = 5'd9; RA2 = 5'd31;
        #1;
        check("fill_rd1", rd1, 32'hA5A5_0009);
        check("fill_rd2", rd2, 32'hA5A5_001F);
        WE = 1'b1; WA = 5'd20; WD = 32'hDEAD_BEEF;
        #2;
        RESET = 1'b1;
        #1;
        check("mrst_rd1", rd1, 32'd0);
        check("mrst_rd2", rd2, 32'd0);
        check("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mrst_wb_data", wb_data, 32'd0);
        tick();
        RESET = 1'b0; WE = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            check("mrst_sweep_rd1", rd1, 32'd0);
            check("mrst_sweep_rd2", rd2, 32'd0);
        end

        // full sweep with complementary read pairs
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            check("sweep_rd1", rd1, model[i]);
            check("sweep_rd2", rd2, model[31 - i]);
        end

        // ALU add write-back into reg 31: 30*0x01010101 + 29*0x01010101
        RA1 = 5'd30; RA2 = 5'd29;
        #1;
        alu_result = rd1 + rd2;
        write_reg(5'd31, alu_result);
        RA1 = 5'd31;
        #1;
        check("alu_r31", rd1, 32'h3B3B_3B3B);
        check("alu_wb_data", wb_data, 32'h3B3B_3B3B);

        // wrap-around: 0xF0000000 + 0x1D1D1D1D
        write_reg(5'd30, 32'hF000_0000);
        RA1 = 5'd30; RA2 = 5'd29;
        #1;
        alu_result = rd1 + rd2;
        write_reg(5'd31, alu_result);
        RA1 = 5'd31; RA2 = 5'd31;
        #1;
        check("alu_wrap_rd1", rd1, 32'h0D1D_1D1D);
        check("alu_wrap_rd2", rd2, 32'h0D1D_1D1D);
        check("alu_wrap_nb", rd1_nb, 32'h0D1D_1D1D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // guard against a stuck run
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
